// File: rtl/issue_pkg.sv
// -----------------------------------------------------------------------------
// issue_pkg
// Shared definitions for the R-type issue unit: opcode constants, ALUop
// encodings, the issue FSM state type, the decoded-instruction struct and
// the decode function used by the top level.
// -----------------------------------------------------------------------------
package issue_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;

    typedef enum logic [1:0] {IDLE, ISSUE, STALL} state_e;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       we;
        logic       reads_rs1;
        logic       reads_rs2;
        logic [1:0] ALUop;
        logic [5:0] func;
        logic       legal;
    } dec_t;

    // Fields an opcode does not define (rd/func for sw and beq, rs2 for lw)
    // decode to 0 so the datapath sees a deterministic value.
    function automatic dec_t decode(input logic [31:0] w);
        dec_t d;
        d = '0;
        case (w[31:26])
            OP_RTYPE: begin
                d.rs1 = w[25:21]; d.rs2 = w[20:16]; d.rd = w[15:11];
                d.we = 1'b1; d.reads_rs1 = 1'b1; d.reads_rs2 = 1'b1;
                d.ALUop = ALUOP_R; d.func = w[5:0]; d.legal = 1'b1;
            end
            OP_LW: begin
                d.rs1 = w[25:21]; d.rd = w[20:16];
                d.we = 1'b1; d.reads_rs1 = 1'b1;
                d.ALUop = ALUOP_MEM; d.legal = 1'b1;
            end
            OP_SW: begin
                d.rs1 = w[25:21]; d.rs2 = w[20:16];
                d.reads_rs1 = 1'b1; d.reads_rs2 = 1'b1;
                d.ALUop = ALUOP_MEM; d.legal = 1'b1;
            end
            OP_BEQ: begin
                d.rs1 = w[25:21]; d.rs2 = w[20:16];
                d.reads_rs1 = 1'b1; d.reads_rs2 = 1'b1;
                d.ALUop = ALUOP_BR; d.legal = 1'b1;
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_scoreboard
// WB_LAT-deep shift register of {wr, rd} for in-flight RF writes, advanced
// every cycle, plus the RAW hazard compare against the held instruction.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   i_push_wr, i_push_rd entry shifted in this cycle (wr=0 for bubbles)
//   i_rs1, i_rs2         source registers of the held instruction
//   i_rd_rs1, i_rd_rs2   which sources the held instruction actually reads
//   o_hazard             some in-flight write targets a read source
// -----------------------------------------------------------------------------
module issue_scoreboard #(
    parameter int WB_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push_wr,
    input  logic [4:0] i_push_rd,
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    input  logic       i_rd_rs1,
    input  logic       i_rd_rs2,
    output logic       o_hazard
);

    logic [WB_LAT-1:0]      r_wr;
    logic [WB_LAT-1:0][4:0] r_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            r_wr[0] <= i_push_wr;
            r_rd[0] <= i_push_rd;
            for (int i = 1; i < WB_LAT; i++) begin
                r_wr[i] <= r_wr[i-1];
                r_rd[i] <= r_rd[i-1];
            end
        end
    end

    // $0 is compared like any other register: the RF here does not hard-wire it.
    always_comb begin
        o_hazard = 1'b0;
        for (int i = 0; i < WB_LAT; i++) begin
            if (r_wr[i] && ((i_rd_rs1 && r_rd[i] == i_rs1) ||
                            (i_rd_rs2 && r_rd[i] == i_rs2)))
                o_hazard = 1'b1;
        end
    end

endmodule

// File: rtl/rtype_issue_unit.sv
// -----------------------------------------------------------------------------
// rtype_issue_unit
// Accepts MIPS-style instruction words over valid/ready into a one-entry hold
// register, decodes them into ALU/ALUControl/RF control fields and issues at
// most one per cycle, inserting bubbles while a read source has an RF write
// still in flight.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   instr_valid, instr          upstream instruction word
//   instr_ready                 hold register can take a word this cycle
//   issue_valid                 registered fields carry a real instruction
//   rs1, rs2, rd, we            RF addresses / write enable
//   ALUop, func                 to ALUControl
//   illegal                     one-cycle pulse: unsupported opcode dropped
//   issued_cnt, bubble_cnt      only with ISSUE_STATS_EN defined
// Optional feature macro: ISSUE_STATS_EN (issue/bubble counters).
// -----------------------------------------------------------------------------
module rtype_issue_unit
    import issue_pkg::*;
#(
    parameter int WB_LAT = 2,
    parameter int XLEN   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [XLEN-1:0] instr,
    output logic            instr_ready,
    output logic            issue_valid,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            we,
    output logic [1:0]      ALUop,
    output logic [5:0]      func,
    output logic            illegal
`ifdef ISSUE_STATS_EN
    ,
    output logic [31:0]     issued_cnt,
    output logic [31:0]     bubble_cnt
`endif
);

    state_e          r_state, w_next;
    logic [XLEN-1:0] r_hold;
    dec_t            w_dec;
    logic            w_hold_valid, w_hazard, w_fire, w_drop, w_accept;

    logic       r_issue_valid, r_we, r_illegal;
    logic [4:0] r_rs1, r_rs2, r_rd;
    logic [1:0] r_aluop;
    logic [5:0] r_func;

    assign w_dec        = decode(r_hold);
    assign w_hold_valid = (r_state != IDLE);
    assign w_accept     = instr_valid & instr_ready;

    issue_scoreboard #(.WB_LAT(WB_LAT)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_push_wr(w_fire & w_dec.we),
        .i_push_rd(w_dec.rd),
        .i_rs1    (w_dec.rs1),
        .i_rs2    (w_dec.rs2),
        .i_rd_rs1 (w_dec.reads_rs1),
        .i_rd_rs2 (w_dec.reads_rs2),
        .o_hazard (w_hazard)
    );

    // State register (reset drops any held word)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state. The hazard is re-evaluated every held cycle, so a STALL
    // fires in the same cycle the hazard clears rather than a cycle later.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = ISSUE;
            default: begin
                if (w_fire || w_drop) w_next = w_accept ? ISSUE : IDLE;
                else                  w_next = STALL;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        w_fire      = w_hold_valid & w_dec.legal & ~w_hazard;
        w_drop      = w_hold_valid & ~w_dec.legal;
        instr_ready = ~w_hold_valid | w_fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_hold <= '0;
        else if (w_accept) r_hold <= instr;
    end

    // Registered datapath fields; they keep their last values across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_valid <= 1'b0;
            r_we          <= 1'b0;
            r_illegal     <= 1'b0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_rd          <= '0;
            r_aluop       <= ALUOP_MEM;
            r_func        <= '0;
        end else begin
            r_issue_valid <= w_fire;
            r_we          <= w_fire & w_dec.we;
            r_illegal     <= w_drop;
            if (w_fire) begin
                r_rs1   <= w_dec.rs1;
                r_rs2   <= w_dec.rs2;
                r_rd    <= w_dec.rd;
                r_aluop <= w_dec.ALUop;
                r_func  <= w_dec.func;
            end
        end
    end

    assign issue_valid = r_issue_valid;
    assign we          = r_we;
    assign illegal     = r_illegal;
    assign rs1         = r_rs1;
    assign rs2         = r_rs2;
    assign rd          = r_rd;
    assign ALUop       = r_aluop;
    assign func        = r_func;

`ifdef ISSUE_STATS_EN
    logic [31:0] r_issued_cnt, r_bubble_cnt;

    // A stalled cycle is one where a held instruction is blocked by a hazard;
    // each such cycle yields exactly one bubble on the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issued_cnt <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_fire)                  r_issued_cnt <= r_issued_cnt + 32'd1;
            if (w_hold_valid & w_hazard) r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign issued_cnt = r_issued_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: doc/rtype_issue_unit.md
Name: rtype_issue_unit

Overview:
- Instruction-side driver for the ALU / ALUControl / RF datapath.
- Accepts 32-bit MIPS-style instruction words over a valid/ready handshake and decodes them into the datapath control fields rs1, rs2, rd, we, ALUop and func.
- Issues at most one instruction per cycle.
- Inserts bubbles (we=0) whenever a source register matches a destination whose RF write-back is still in flight.

Parameters:
- WB_LAT, 2: cycles from issue until the RF write of that rd becomes readable; range 1..4.
- XLEN, 32: instruction word width; fixed at 32, other values unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- instr_valid  input  1  upstream instruction word is valid
- instr  input  32  instruction word
- instr_ready  output  1  unit can accept `instr` this cycle
- issue_valid  output  1  datapath fields below carry a real instruction this cycle
- rs1  output  5  RF read address A
- rs2  output  5  RF read address B
- rd  output  5  RF write address
- we  output  1  RF write enable
- ALUop  output  2  to ALUControl
- func  output  6  to ALUControl
- illegal  output  1  one-cycle pulse: unsupported opcode dropped

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: issue_valid=0, we=0, rs1=rs2=rd=0, ALUop=2'b00, func=0, illegal=0.
  - Internal state: hold register empty, scoreboard cleared, FSM to IDLE.
  - Reset asserted mid-stall drops the held instruction.
- Front end is a one-entry hold register.
  - instr_ready = !hold_valid | issue_fire, combinational.
  - Accept occurs when instr_valid & instr_ready at a rising edge.
- Decode rules (opcode = instr[31:26]):
  - 000000 (R-type): ALUop=10, func=instr[5:0], rs1=[25:21], rs2=[20:16], rd=[15:11], we=1. Reads rs1 and rs2.
  - 100011 (lw): ALUop=00, func=0, rs1=[25:21], rd=[20:16], rs2=0, we=1. Reads rs1 only.
  - 101011 (sw): ALUop=00, rs1=[25:21], rs2=[20:16], we=0. Reads both.
  - 000100 (beq): ALUop=01, rs1=[25:21], rs2=[20:16], we=0. Reads both.
  - Any other opcode is consumed from hold without issuing; illegal=1 for exactly that cycle.
- Scoreboard: WB_LAT-deep shift register of {wr, rd}, advanced every cycle. Bubbles shift in wr=0.
- Hazard condition: some slot has wr=1 and its rd equals a register the held instruction actually reads. Register 0 is NOT special-cased.
- FSM states and transitions:
  - IDLE: hold empty. On accept, go to ISSUE.
  - ISSUE: if no hazard, issue_fire=1. The next edge registers the outputs with issue_valid=1; go to IDLE, or stay in ISSUE if a new instruction was accepted in the same cycle. If hazard, go to STALL.
  - STALL: outputs issue_valid=0, we=0; rs1/rs2/rd/ALUop/func hold their last values. Returns to ISSUE when the hazard clears. A stall never exceeds WB_LAT cycles.
- Latency: accept at edge N → issue at edge N+1 when there is no hazard.
- Throughput: 1 instruction/cycle for independent instructions.
- Back-to-back dependent R-type instructions with WB_LAT=2 produce exactly 2 bubbles.
- Simultaneous accept and issue is legal: hold is refilled in the same edge.
- we is never 1 while issue_valid=0.

Optional Feature:
- Macro: ISSUE_STATS_EN.
- Defined: adds outputs issued_cnt[31:0] and bubble_cnt[31:0].
  - Both reset to 0 and wrap at 2^32.
  - issued_cnt increments on issue_fire; bubble_cnt increments on each STALL cycle.
- Undefined: the ports and counters are absent; functional behaviour is otherwise identical.

Decomposition:
- Package issue_pkg holds:
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ.
  - ALUop encodings: ALUOP_MEM=00, ALUOP_BR=01, ALUOP_R=10.
  - FSM state typedef: IDLE, ISSUE, STALL.
  - A decoded-instruction struct: rs1, rs2, rd, we, reads_rs1, reads_rs2, ALUop, func, legal.
- One sub-module, issue_scoreboard: the WB_LAT-deep {wr, rd} shift register plus the hazard compare.

Test Plan:
- Reset: hold rst_n=0 while instr_valid=1 → issue_valid=0, we=0, all fields 0, instr_ready=1 after release.
- Independent stream: add $1,$2,$3 (func 100000) then sub $4,$5,$6 (func 100010), back-to-back → issued on consecutive cycles; ALUop=10, func correct, zero bubbles.
- RAW hazard with WB_LAT=2: add $7,$7,$7 then add $8,$7,$7 → 2 cycles with issue_valid=0, we=0; the second instruction issues on the 3rd cycle; instr_ready=0 during the stall.
- Register-0 dependency: add $0,$1,$1 then add $2,$0,$0 → the stall is still inserted.
- Mixed opcodes: lw $9,0($10), sw $9,4($10), beq $1,$2, opcode 111111 →
  - lw: ALUop=00, we=1.
  - sw: stalls on $9, then ALUop=00, we=0.
  - beq: ALUop=01, we=0.
  - 111111: illegal pulses once, no issue.
- Mid-stall reset: assert rst_n=0 during the bubble of the hazard case → held instruction is discarded. With ISSUE_STATS_EN, issued_cnt=0 and bubble_cnt=0 afterwards.
